// File: rtl/ps2_msg_framer_pkg.sv
// Shared types and helpers for the PS/2 message framer.
// Holds the framer state encoding and shift-register sizing.
package ps2_pkg;

    localparam int PS2_BYTE_W = 8;

    typedef enum logic [1:0] {
        SEARCH,
        COLLECT,
        DONE
    } ps2_frm_state_e;

    function automatic int ps2_shift_w(input int msg_bytes);
        return msg_bytes * PS2_BYTE_W;
    endfunction

endpackage

// File: rtl/ps2_msg_framer_if.sv
// Byte-stream input and framed-message output bundle for the framer.
// master drives the byte stream, slave is the framer itself.
interface ps2_msg_framer_if #(
    parameter int MSG_BYTES = 3,
    parameter int CNT_W     = 16
);
    import ps2_pkg::*;

    logic [PS2_BYTE_W-1:0]             din;
    logic                              din_valid;
    logic                              done;
    logic [ps2_shift_w(MSG_BYTES)-1:0] msg_out;
    logic [CNT_W-1:0]                  msg_cnt;
    logic                              timeout_err;

    modport master (
        output din,
        output din_valid,
        input  done,
        input  msg_out,
        input  msg_cnt,
        input  timeout_err
    );

    modport slave (
        input  din,
        input  din_valid,
        output done,
        output msg_out,
        output msg_cnt,
        output timeout_err
    );

endinterface

// File: rtl/ps2_msg_framer.sv
// Frames fixed-length PS/2 messages from a qualified byte stream.
// Define PS2_FRAMER_TIMEOUT_EN to abort stalled messages after TIMEOUT_CYC idle cycles.
module ps2_msg_framer
    import ps2_pkg::*;
#(
    parameter int MSG_BYTES   = 3,
    parameter int SYNC_BIT    = 3,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    ps2_msg_framer_if.slave   bus
);

    localparam int SHW   = ps2_shift_w(MSG_BYTES);
    localparam int IDX_W = $clog2(MSG_BYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    ps2_frm_state_e   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SHW-1:0]   shift_q, shift_d;
    logic [SHW-1:0]   msg_q, msg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync_hit;

    assign sync_hit = bus.din_valid && bus.din[SYNC_BIT];

`ifdef PS2_FRAMER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] IDLE_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] idle_q, idle_d;
    logic            to_q, to_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SEARCH;
            idx_q   <= '0;
            shift_q <= '0;
            msg_q   <= '0;
            cnt_q   <= '0;
`ifdef PS2_FRAMER_TIMEOUT_EN
            idle_q  <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            msg_q   <= msg_d;
            cnt_q   <= cnt_d;
`ifdef PS2_FRAMER_TIMEOUT_EN
            idle_q  <= idle_d;
            to_q    <= to_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        msg_d   = msg_q;
        cnt_d   = cnt_q;
`ifdef PS2_FRAMER_TIMEOUT_EN
        idle_d  = '0;
        to_d    = 1'b0;
`endif
        unique case (state_q)
            // DONE accepts input exactly like SEARCH so a sync byte is never lost
            SEARCH, DONE: begin
                state_d = SEARCH;
                idx_d   = '0;
                if (sync_hit) begin
                    shift_d = SHW'(bus.din);
                    idx_d   = IDX_ONE;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.din_valid) begin
                    shift_d = {shift_q[SHW-PS2_BYTE_W-1:0], bus.din};
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = DONE;
                        msg_d   = shift_d;
                        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
`ifdef PS2_FRAMER_TIMEOUT_EN
                    if (idle_q == IDLE_LAST) begin
                        state_d = SEARCH;
                        idx_d   = '0;
                        to_d    = 1'b1;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = SEARCH;
                idx_d   = '0;
            end
        endcase
    end

    assign bus.done    = (state_q == DONE);
    assign bus.msg_out = msg_q;
    assign bus.msg_cnt = cnt_q;

`ifdef PS2_FRAMER_TIMEOUT_EN
    assign bus.timeout_err = to_q;
`else
    // No idle supervision in this build; always low
    assign bus.timeout_err = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_ps2_msg_framer.sv
// Directed plus randomized bench for ps2_msg_framer against a queue-based message model.
// Two instances share the stream: a 16-bit counter and a 2-bit saturating counter.
module tb_ps2_msg_framer;
    import ps2_pkg::*;

    localparam int MB = 3;
    localparam int SB = 3;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    ps2_msg_framer_if #(.MSG_BYTES(MB), .CNT_W(16)) bus ();
    ps2_msg_framer_if #(.MSG_BYTES(MB), .CNT_W(2))  bus2 ();

    assign bus2.din       = bus.din;
    assign bus2.din_valid = bus.din_valid;

    ps2_msg_framer #(
        .MSG_BYTES(MB), .SYNC_BIT(SB), .CNT_W(16), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    ps2_msg_framer #(
        .MSG_BYTES(MB), .SYNC_BIT(SB), .CNT_W(2), .TIMEOUT_CYC(TO)
    ) dut_sat (
        .clk(clk), .reset_n(reset_n), .bus(bus2)
    );

    logic [7:0]  q[$];
    int          idle;
    logic        m_done, m_to, m_to2;
    logic [23:0] m_msg;
    int          m_cnt, m_cnt2;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic void model_reset();
        q.delete();
        idle   = 0;
        m_done = 1'b0;
        m_to   = 1'b0;
        m_msg  = '0;
        m_cnt  = 0;
        m_cnt2 = 0;
    endfunction

    function automatic void model_step(input logic v, input logic [7:0] d);
        m_done = 1'b0;
        m_to   = 1'b0;
        if (v) begin
            idle = 0;
            if (q.size() == 0) begin
                if (d[SB]) q.push_back(d);
            end else begin
                q.push_back(d);
                if (q.size() == MB) begin
                    m_msg = '0;
                    foreach (q[i]) m_msg = (m_msg << 8) | 24'(q[i]);
                    m_done = 1'b1;
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                    q.delete();
                end
            end
        end else if (q.size() != 0) begin
`ifdef PS2_FRAMER_TIMEOUT_EN
            idle++;
            if (idle == TO) begin
                q.delete();
                idle = 0;
                m_to = 1'b1;
            end
`endif
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".done"}, 32'(bus.done), 32'(m_done));
        chk({tag, ".msg"}, 32'(bus.msg_out), 32'(m_msg));
        chk({tag, ".cnt"}, 32'(bus.msg_cnt), 32'(m_cnt));
        chk({tag, ".cnt2"}, 32'(bus2.msg_cnt), 32'(m_cnt2));
        chk({tag, ".to"}, 32'(bus.timeout_err), 32'(m_to));
        chk({tag, ".done2"}, 32'(bus2.done), 32'(m_done));
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input string tag);
        bus.din_valid = v;
        bus.din       = d;
        @(posedge clk);
        model_step(v, d);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.din_valid = 1'b0;
        model_reset();
        #1;
        check_all("reset_async");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        model_reset();
        @(negedge clk);
        check_all("reset");
        chk("reset_msg", 32'(bus.msg_out), 32'h0);
        reset_n = 1'b1;

        // basic frame
        cyc(1'b1, 8'h2C, "basic0");
        cyc(1'b1, 8'h81, "basic1");
        chk("basic_nodone", 32'(bus.done), 32'h0);
        cyc(1'b1, 8'h09, "basic2");
        chk("basic_done", 32'(bus.done), 32'h1);
        chk("basic_msg", 32'(bus.msg_out), 32'h2C8109);
        chk("basic_cnt", 32'(bus.msg_cnt), 32'h1);
        cyc(1'b0, 8'h00, "basic_idle");
        chk("basic_pulse", 32'(bus.done), 32'h0);
        chk("basic_hold", 32'(bus.msg_out), 32'h2C8109);

        // resync
        cyc(1'b1, 8'h00, "rs0");
        cyc(1'b1, 8'h10, "rs1");
        cyc(1'b1, 8'h08, "rs2");
        cyc(1'b1, 8'hFF, "rs3");
        cyc(1'b1, 8'h00, "rs4");
        chk("resync_done", 32'(bus.done), 32'h1);
        chk("resync_msg", 32'(bus.msg_out), 32'h08FF00);

        // back-to-back with a gap; sync byte lands in the DONE cycle
        cyc(1'b1, 8'h08, "bb0");
        cyc(1'b1, 8'h01, "bb1");
        cyc(1'b0, 8'h55, "bb_gap");
        cyc(1'b1, 8'h02, "bb2");
        chk("bb_msg_a", 32'(bus.msg_out), 32'h080102);
        cyc(1'b1, 8'h0F, "bb3");
        chk("bb_done_drop", 32'(bus.done), 32'h0);
        cyc(1'b1, 8'h03, "bb4");
        cyc(1'b1, 8'h04, "bb5");
        chk("bb_done_b", 32'(bus.done), 32'h1);
        chk("bb_msg_b", 32'(bus.msg_out), 32'h0F0304);
        chk("bb_cnt", 32'(bus.msg_cnt), 32'h4);

        // reset mid-message
        cyc(1'b1, 8'h08, "rm0");
        cyc(1'b1, 8'h11, "rm1");
        do_reset();
        cyc(1'b1, 8'h22, "rm2");
        cyc(1'b1, 8'h33, "rm3");
        chk("rm_done", 32'(bus.done), 32'h0);
        chk("rm_msg", 32'(bus.msg_out), 32'h0);
        chk("rm_cnt", 32'(bus.msg_cnt), 32'h0);

        // saturation of the 2-bit counter
        for (int m = 0; m < 5; m++) begin
            cyc(1'b1, 8'h08, "sat0");
            cyc(1'b1, 8'(m), "sat1");
            cyc(1'b1, 8'h00, "sat2");
            if (m == 2) chk("sat_at3", 32'(bus2.msg_cnt), 32'h3);
        end
        chk("sat_hold", 32'(bus2.msg_cnt), 32'h3);
        chk("sat_wide", 32'(bus.msg_cnt), 32'h5);

        // idle stall mid-message
        cyc(1'b0, 8'h00, "to_pre");
        cyc(1'b1, 8'h08, "to0");
        cyc(1'b1, 8'h01, "to1");
        for (int i = 0; i < TO; i++) cyc(1'b0, 8'h00, "to_idle");
`ifdef PS2_FRAMER_TIMEOUT_EN
        chk("to_pulse", 32'(bus.timeout_err), 32'h1);
        cyc(1'b1, 8'h02, "to2");
        chk("to_nodone", 32'(bus.done), 32'h0);
        chk("to_cnt", 32'(bus.msg_cnt), 32'h5);
`else
        chk("to_tied", 32'(bus.timeout_err), 32'h0);
        cyc(1'b1, 8'h02, "to2");
        chk("to_waits", 32'(bus.msg_out), 32'h080102);
`endif
        cyc(1'b0, 8'h00, "to_post");

        // randomized stream
        for (int n = 0; n < 600; n++) begin
            logic       v;
            logic [7:0] d;
            if (n == 300) do_reset();
            if ($urandom_range(0, 19) == 0) begin
                for (int k = 0; k < $urandom_range(3, 6); k++)
                    cyc(1'b0, 8'($urandom), "rnd_idle");
            end
            v = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            cyc(v, d, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
